// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the fetch / load-store memory port arbiter.
package cpu_mem_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the memory port arbiter.
// master: the arbiter itself; slave: the surrounding fetch/load-store/memory environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = cpu_mem_pkg::CPU_ADDR_W,
  parameter int DATA_W = cpu_mem_pkg::CPU_DATA_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// mem_lat_timer: loadable down-counter timing the memory read latency.
// done is high while the count equals 1, i.e. in the cycle mem_rdata is valid.
module mem_lat_timer
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic done
);

  localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(MEM_LAT);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign done = (count_reg == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data memory between instruction fetch and load/store.
// Optional macro STARVE_GUARD_EN: after STARVE_MAX consecutive IF losses, IF wins the next contention.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DATA_W     = CPU_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be >= 1");
  end

  arb_state_e        state_reg;
  arb_state_e        state_next;
  owner_e            owner_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic              grant_ok;
  logic              d_wins;
  logic              grant;
  logic              timer_load;
  logic              timer_done;
  logic              read_done;

  // Grants are only given from IDLE and never while reset is asserted.
  assign grant_ok = (state_reg == IDLE) && !reset;

`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_reg;

  assign d_wins = bus.d_req && !(bus.if_req && (starve_reg == SW'(STARVE_MAX)));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (bus.if_gnt) begin
        starve_reg <= '0;
      end else if (bus.d_gnt && bus.if_req) begin
        if (starve_reg != SW'(STARVE_MAX)) begin
          starve_reg <= starve_reg + SW'(1);
        end
      end else if (!bus.if_req) begin
        starve_reg <= '0;
      end
    end
  end
`else
  assign d_wins = bus.d_req;
`endif

  assign bus.d_gnt  = grant_ok && d_wins;
  assign bus.if_gnt = grant_ok && bus.if_req && !d_wins;
  assign grant      = bus.d_gnt || bus.if_gnt;

  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (we_reg) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT;
          timer_load = 1'b1;
        end
      end
      WAIT: begin
        if (timer_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= OWN_IF;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        owner_reg <= d_wins ? OWN_D : OWN_IF;
        we_reg    <= d_wins && bus.d_we;
        addr_reg  <= d_wins ? bus.d_addr : bus.if_addr;
        wdata_reg <= d_wins ? bus.d_wdata : '0;
      end
    end
  end

  mem_lat_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .clear (read_done),
    .done  (timer_done)
  );

  // A read aborted by reset must not deliver data, even if mem_rdata shows up.
  assign read_done = (state_reg == WAIT) && timer_done && !reset;

  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_read  = (state_reg == ACCESS) && !we_reg && !reset;
  assign bus.mem_write = (state_reg == ACCESS) && we_reg && !reset;

  assign bus.if_rvalid = read_done && (owner_reg == OWN_IF);
  assign bus.d_rvalid  = read_done && (owner_reg == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;

  assign bus.busy = (state_reg != IDLE);

  a_gnt_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(bus.if_gnt && bus.d_gnt));
  a_strobe_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(bus.mem_read && bus.mem_write));

endmodule
